chebyshev_output_stage: RTL and testbench

Output stage directly downstream of the Chebyshev computation datapath in chebyshev_control. It takes the full-width signed polynomial result, rounds it to O_BITS and saturates it. Results are buffered in a small FIFO and presented on the module's source_valid/source_ready handshake. Its sink_ready gives backpressure to the control FSM, so no result is ever dropped.

---
 rtl/chebyshev_pkg.sv | 15 +
 rtl/chebyshev_round_sat.sv | 34 +++
 rtl/chebyshev_output_stage.sv | 110 +++++++++++
 tb/tb_chebyshev_output_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chebyshev_pkg.sv
// rtl/chebyshev_pkg.sv - shared widths and defaults for the Chebyshev approximation blocks
package chebyshev_pkg;

  localparam int WL            = 16;
  localparam int CL            = 4;
  localparam int COMP_WIDENING = 4;
  localparam int COMP_OUT      = 2 * WL + CL + COMP_WIDENING;

  localparam int O_BITS        = 16;
  localparam int FRAC_SHIFT    = 24;

  localparam int DEPTH         = 4;
  localparam int AW            = 2;

endpackage

// File: rtl/chebyshev_round_sat.sv
// rtl/chebyshev_round_sat.sv - round half toward +inf, then saturate to O_BITS signed
module chebyshev_round_sat #(
  parameter int CW         = 40,
  parameter int FRAC_SHIFT = 24,
  parameter int O_BITS     = 16
) (
  input  logic [CW-1:0]     value_in,
  output logic [O_BITS-1:0] value_out,
  output logic              clip
);

  localparam logic [CW:0] HALF = {{CW{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

  logic signed [CW:0] biased;
  logic signed [CW:0] shifted;
  logic               ovf_pos;
  logic               ovf_neg;

  // One guard bit above CW keeps the rounding bias from wrapping.
  assign biased  = $signed({value_in[CW-1], value_in}) + $signed(HALF);
  assign shifted = biased >>> FRAC_SHIFT;

  // In range only when every bit from the output sign upward matches the sign.
  assign ovf_pos = !shifted[CW] && (|shifted[CW-1:O_BITS-1]);
  assign ovf_neg =  shifted[CW] && !(&shifted[CW-1:O_BITS-1]);
  assign clip    = ovf_pos || ovf_neg;

  always_comb begin
    value_out = shifted[O_BITS-1:0];
    if (ovf_pos) value_out = {1'b0, {(O_BITS-1){1'b1}}};
    else if (ovf_neg) value_out = {1'b1, {(O_BITS-1){1'b0}}};
  end

endmodule

// File: rtl/chebyshev_output_stage.sv
// rtl/chebyshev_output_stage.sv - round/saturate register stage feeding a small result FIFO
module chebyshev_output_stage
  import chebyshev_pkg::*;
#(
  parameter int CW         = COMP_OUT,
  parameter int FRAC_SHIFT = chebyshev_pkg::FRAC_SHIFT,
  parameter int O_BITS     = chebyshev_pkg::O_BITS,
  parameter int DEPTH      = chebyshev_pkg::DEPTH,
  parameter int AW         = chebyshev_pkg::AW
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [CW-1:0]     data_in,
  input  logic              sink_valid,
  output logic              sink_ready,
  output logic [O_BITS-1:0] data_out,
  output logic              source_valid,
  input  logic              source_ready,
  output logic              sat_event,
  output logic [15:0]       sat_count
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW+1:0] OCC_LIM  = (AW + 2)'(DEPTH);

  logic [O_BITS-1:0] rs_out;
  logic              rs_clip;

  logic [O_BITS-1:0] stage_reg;
  logic              stage_clip;
  logic              stage_vld;

  logic [O_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [AW+1:0]     occ;

  chebyshev_round_sat #(
    .CW         (CW),
    .FRAC_SHIFT (FRAC_SHIFT),
    .O_BITS     (O_BITS)
  ) u_round_sat (
    .value_in  (data_in),
    .value_out (rs_out),
    .clip      (rs_clip)
  );

  // Occupancy counts the in-flight stage entry so the FIFO always has room for it.
  assign occ          = {1'b0, count} + (AW + 2)'(stage_vld);
  assign sink_ready   = occ < OCC_LIM;
  assign accept       = sink_valid && sink_ready;
  assign wr_en        = stage_vld;
  assign source_valid = count != '0;
  assign rd_en        = source_valid && source_ready;
  assign data_out     = mem[rd_ptr];
  assign sat_event    = stage_vld && stage_clip;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stage_vld  <= 1'b0;
      stage_reg  <= '0;
      stage_clip <= 1'b0;
    end else begin
      stage_vld <= accept;
      if (accept) begin
        stage_reg  <= rs_out;
        stage_clip <= rs_clip;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= stage_reg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sat_count <= '0;
    end else if (sat_event && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(wr_en && (count == FULL_CNT)));
  a_no_underflow: assert property (@(posedge clock) disable iff (!resetn)
    !(rd_en && (count == '0)));

endmodule

// File: tb/tb_chebyshev_output_stage.sv
// tb/tb_chebyshev_output_stage.sv - scoreboard bench for the round/saturate output stage
module tb_chebyshev_output_stage;

  logic        clock;
  logic        resetn;
  logic [39:0] data_in;
  logic        sink_valid;
  logic        sink_ready;
  logic [15:0] data_out;
  logic        source_valid;
  logic        source_ready;
  logic        sat_event;
  logic [15:0] sat_count;

  int checks    = 0;
  int failures  = 0;
  int exp_clips = 0;
  int obs_sat   = 0;
  bit done_rand = 0;

  logic [15:0] sb[$];
  bit          held;
  logic [15:0] held_val;

  chebyshev_output_stage dut (
    .clock        (clock),
    .resetn       (resetn),
    .data_in      (data_in),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .data_out     (data_out),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .sat_event    (sat_event),
    .sat_count    (sat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact floor((x + 2^23) / 2^24), then clamp to the signed 16-bit range.
  function automatic void model(input logic [39:0] v, output logic [15:0] o, output bit c);
    longint s, q, r;
    s = longint'($signed(v));
    q = s + 64'sd8388608;
    if (q >= 0) r = q / 64'sd16777216;
    else        r = -((-q + 64'sd16777215) / 64'sd16777216);
    c = 1'b0;
    if (r > 32767) begin
      o = 16'h7FFF; c = 1'b1;
    end else if (r < -32768) begin
      o = 16'h8000; c = 1'b1;
    end else begin
      o = r[15:0];
    end
  endfunction

  always @(negedge clock) begin
    logic [15:0] e;
    bit          c;
    if (!resetn) begin
      sb.delete();
      held = 1'b0;
    end else begin
      if (sat_event) obs_sat++;
      if (held) check("hold_stable", data_out, held_val);
      if (source_valid && source_ready) begin
        if (sb.size() == 0) check("pop_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("data_out", data_out, e);
        end
      end
      held     = source_valid && !source_ready;
      held_val = data_out;
      if (sink_valid && sink_ready) begin
        model(data_in, e, c);
        sb.push_back(e);
        if (c) exp_clips++;
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic offer(input logic [39:0] v);
    int n = 0;
    data_in    = v;
    sink_valid = 1'b1;
    @(negedge clock);
    while (!sink_ready && n < 1000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 1000) check("offer_timeout", 0, 1);
    @(posedge clock); #1;
    sink_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    source_ready = 1'b1;
    while ((sb.size() != 0 || source_valid) && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_done", (sb.size() == 0 && !source_valid), 1);
  endtask

  task automatic latency(input logic [39:0] v);
    check("lat_ready", sink_ready, 1);
    data_in    = v;
    sink_valid = 1'b1;
    @(posedge clock); #1;
    sink_valid = 1'b0;
    check("lat_edge_k", source_valid, 0);
    @(posedge clock); #1;
    check("lat_edge_k1", source_valid, 1);
    @(posedge clock); #1;
  endtask

  task automatic fill4(input int base);
    source_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", sink_ready, 1);
      offer(40'(base + i) << 24);
    end
    check("full_ready_low", sink_ready, 0);
  endtask

  function automatic logic [39:0] rand_value();
    logic [31:0] a, b;
    logic [39:0] v;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 3))
      0: v = {a[7:0], b};
      1: v = {{8{a[31]}}, a};
      2: v = 40'h7FFF800000 + 40'($signed(b[11:0])) - 40'd2048;
      default: v = {a[15:0], b[0] ? 24'h800000 : 24'h7FFFFF};
    endcase
    return v;
  endfunction

  initial begin
    resetn       = 1'b0;
    data_in      = '0;
    sink_valid   = 1'b0;
    source_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_source_valid", source_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_sat_event", sat_event, 0);
    check("rst_sink_ready", sink_ready, 1);
    resetn = 1'b1;

    // Mid-stream reset with three values buffered, one of them clipped.
    offer(40'h0001000000);
    offer(40'h7FFFFFFFFF);
    offer(40'h0003000000);
    @(posedge clock); #1;
    check("pre_rst_valid", source_valid, 1);
    check("pre_rst_sat_count", sat_count, 16'(exp_clips));
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_source_valid", source_valid, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_sat_count", sat_count, 0);
    @(negedge clock);
    @(posedge clock); #1;
    resetn = 1'b1;
    check("post_rst_sink_ready", sink_ready, 1);
    exp_clips    = 0;
    obs_sat      = 0;
    source_ready = 1'b1;
    latency(40'h0005000000);

    // Rounding at the half-LSB points.
    latency(40'h0001800000);
    latency(40'h00017FFFFF);
    latency(40'hFFFE800000);
    latency(40'hFFFE7FFFFF);
    check("round_no_sat", obs_sat, 0);

    // Saturation and its boundary.
    offer(40'h7FFFFFFFFF);
    offer(40'h8000000000);
    offer(40'h7FFF7FFFFF);
    offer(40'h7FFF800000);
    offer(40'h007FFF7FFF);
    offer(40'h007FFF8000);
    drain();
    check("sat_pulses", obs_sat, exp_clips);
    check("sat_count", sat_count, 16'(exp_clips));

    // Backpressure: fifth value held off until the consumer drains.
    fill4(1);
    data_in    = 40'h0005000000;
    sink_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("bp_held_off", sb.size(), 4);
    check("bp_ready_low", sink_ready, 0);
    check("bp_head", data_out, 16'h0001);
    source_ready = 1'b1;
    offer(40'h0005000000);
    drain();

    // Full FIFO with a single-cycle pop.
    fill4(6);
    data_in    = 40'h000A000000;
    sink_valid = 1'b1;
    @(posedge clock); #1;
    source_ready = 1'b1;
    @(negedge clock);
    check("pop_cycle_ready_low", sink_ready, 0);
    @(posedge clock); #1;
    source_ready = 1'b0;
    check("after_pop_ready_high", sink_ready, 1);
    @(posedge clock); #1;
    sink_valid = 1'b0;
    check("refilled_ready_low", sink_ready, 0);
    check("refilled_count", sb.size(), 4);
    drain();

    // Random traffic on both handshakes.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(0, 1) == 0) begin
            @(posedge clock); #1;
          end
          offer(rand_value());
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          source_ready = 1'($urandom_range(0, 1));
          @(posedge clock); #1;
        end
      end
    join
    drain();
    check("rand_sat_pulses", obs_sat, exp_clips);
    check("rand_sat_count", sat_count, (exp_clips > 65535) ? 16'hFFFF : 16'(exp_clips));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
